router_sync_nch: RTL

Parametrised successor of the three-channel router synchronizer; sits between the router FSM/register block and NUM_CH output FIFOs.
- Latches the destination address on detect_addr.
- Steers the write enable (one-hot) and selects the matching FIFO full flag.
- Drives per-channel valid outputs.
- Runs one independent read-timeout counter per channel; each counter pulses a soft reset when its channel is left unread for TIMEOUT cycles.
- New versus the previous generation: channel count and timeout are parameters, an illegal address is reported, and idle counters clear correctly.

---
 rtl/router_pkg.sv | 18 +
 rtl/sync_timeout_ctr.sv | 54 +++++
 rtl/router_sync_nch.sv | 86 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router defaults and the counter-width helper used by the
// synchronizer, the output FIFOs and the router top level.
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;

  // Bits needed to hold 0..timeout-1; a counter never exceeds timeout-1.
  function automatic int cnt_width(input int timeout);
    if (timeout <= 2) begin
      return 1;
    end else begin
      return $clog2(timeout);
    end
  endfunction

endpackage

// File: rtl/sync_timeout_ctr.sv
// Single-channel read-timeout counter. Counts consecutive cycles in which
// the channel holds data that nobody reads, and emits a one-cycle
// soft_reset pulse when that run reaches TIMEOUT cycles.
module sync_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Next count: idle or read clears, expiry pulses and restarts, else count.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!vld) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (rd_en) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      pulse_d = 1'b0;
    end
  end

  // Counter and pulse registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_nch.sv
// N-channel router synchronizer: latches the header destination address,
// steers the FSM write request to one FIFO, returns that FIFO's full flag,
// flags addresses with no channel behind them, and runs a read-timeout
// counter per channel.
module router_sync_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] din,
  input  logic              detect_addr,
  input  logic              wr_en_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] rd_en,
  output logic [NUM_CH-1:0] wr_en,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] wr_en_s;
  logic              fifo_full_s;
  logic              addr_err_s;

  // Capture the header address on the detect strobe, otherwise hold.
  always_comb begin
    if (detect_addr) begin
      addr_d = din;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register; reset points at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Decode the latched address; an address matching no channel steers
  // nowhere and raises addr_err. Full-gating is left to the router FSM.
  always_comb begin
    wr_en_s     = '0;
    fifo_full_s = 1'b0;
    addr_err_s  = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        wr_en_s[i]  = wr_en_reg;
        fifo_full_s = full[i];
        addr_err_s  = 1'b0;
      end else begin
        wr_en_s[i]  = 1'b0;
      end
    end
  end

  assign wr_en     = wr_en_s;
  assign fifo_full = fifo_full_s;
  assign addr_err  = addr_err_s;
  assign vld_out   = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld_out[g]),
      .rd_en      (rd_en[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule
